// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with mid-bit sampling and an AXI-Stream-style output.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  rxd_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  busy_o,
  output logic                  overrun_error_o,
  output logic                  frame_error_o
);
  localparam int CW = PRESCALE_W + 3;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_state_n;
  logic r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt, w_cnt_n, r_period, w_period_n;
  logic [BW-1:0] r_bit, w_bit_n;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_n, r_tdata;
  logic r_tvalid, r_ovr, r_fe, w_load, w_fe;
  logic w_edge, w_zero;
  logic [CW-1:0] w_p, w_h;
  assign w_edge = r_prev & ~r_sync2;
  assign w_zero = r_cnt == '0;
  assign w_p = {prescale_i, 3'b000};
  assign w_h = {1'b0, prescale_i, 2'b00};
  assign m_axis_tdata_o = r_tdata;
  assign m_axis_tvalid_o = r_tvalid;
  assign busy_o = r_state != IDLE;
  assign overrun_error_o = r_ovr;
  assign frame_error_o = r_fe;
  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt;
    w_period_n = r_period;
    w_bit_n = r_bit;
    w_shift_n = r_shift;
    w_load = 1'b0;
    w_fe = 1'b0;
    if (r_state == IDLE) begin
      if (w_edge && prescale_i != '0) begin
        w_state_n = START;
        w_cnt_n = w_h - 1'b1;
        w_period_n = w_p;
      end
    end else if (!w_zero) begin
      w_cnt_n = r_cnt - 1'b1;
    end else begin
      w_cnt_n = r_period - 1'b1;
      case (r_state)
        START: begin
          w_state_n = r_sync2 ? IDLE : DATA;
          w_bit_n = '0;
        end
        DATA: begin
          w_shift_n = {r_sync2, r_shift[DATA_WIDTH-1:1]};
          w_bit_n = r_bit + 1'b1;
          w_state_n = r_bit == BW'(DATA_WIDTH - 1) ? STOP : DATA;
        end
        STOP: begin
          w_state_n = IDLE;
          w_load = r_sync2;
          w_fe = ~r_sync2;
        end
        default: w_state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state <= IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev <= 1'b1;
      r_cnt <= '0;
      r_period <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_tdata <= '0;
      r_tvalid <= 1'b0;
      r_ovr <= 1'b0;
      r_fe <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sync1 <= rxd_i;
      r_sync2 <= r_sync1;
      r_prev <= r_sync2;
      r_cnt <= w_cnt_n;
      r_period <= w_period_n;
      r_bit <= w_bit_n;
      r_shift <= w_shift_n;
      if (w_load) r_tdata <= r_shift;
      // a load in the same cycle as an accept keeps tvalid high without an overrun
      r_tvalid <= w_load | (r_tvalid & ~m_axis_tready_i);
      r_ovr <= w_load & r_tvalid & ~m_axis_tready_i;
      r_fe <= w_fe;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; a serial driver queues expected words, a monitor checks them on handshake.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_i = 1'b1;
  logic [15:0] prescale_i = 16'd2;
  logic [7:0] tdata;
  logic tvalid, busy, ovr, fe;
  logic tready = 1'b1;
  int total = 0, bad = 0;
  int cyc = 0, n_rise = 0, n_hs = 0, n_ovr = 0, n_fe = 0, rise_cyc = 0;
  logic prev_tv = 1'b0, prev_busy = 1'b0;
  logic [7:0] q[$];
  uart_rx dut (
    .clk_i(clk), .rst(rst), .rxd_i(rxd_i), .prescale_i(prescale_i),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
    .busy_o(busy), .overrun_error_o(ovr), .frame_error_o(fe)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && !prev_tv) begin
        n_rise++;
        rise_cyc = cyc;
        total++;
        if (busy !== 1'b0 || prev_busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_fall: busy=%b prev_busy=%b at tvalid rise, required 0/1", busy, prev_busy);
        end
      end
      if (tvalid && tready) begin
        total++;
        n_hs++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h, scoreboard empty", tdata);
        end else begin
          logic [7:0] exp;
          exp = q.pop_front();
          if (tdata !== exp) begin
            bad++;
            $display("FAIL word: got %h required %h", tdata, exp);
          end
        end
      end
      if (ovr) n_ovr++;
      if (fe) n_fe++;
    end
    prev_tv = tvalid;
    prev_busy = busy;
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bits(input logic [7:0] d, input logic stop);
    int p;
    p = int'(prescale_i) * 8;
    rxd_i = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rxd_i = d[i];
      tick(p);
    end
    rxd_i = stop;
    tick(p);
  endtask
  task automatic send(input logic [7:0] d);
    q.push_back(d);
    send_bits(d, 1'b1);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    total++;
    if ({tdata, tvalid, busy, ovr, fe} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: tdata=%h tvalid=%b busy=%b ovr=%b fe=%b, required all 0", tdata, tvalid, busy, ovr, fe);
    end
    rst = 1'b0;
    tick(100);
    total++;
    if (n_rise !== 0 || tvalid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_line: rises=%0d tvalid=%b busy=%b, required 0/0/0", n_rise, tvalid, busy);
    end
  endtask
  task automatic test_prescale_zero;
    logic seen;
    seen = 1'b0;
    prescale_i = 16'd0;
    rxd_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen |= busy;
    end
    rxd_i = 1'b1;
    tick(10);
    prescale_i = 16'd2;
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL prescale_zero: busy seen=%b, required 0", seen);
    end
  endtask
  task automatic test_basic;
    int r0, f0, o0, c0;
    r0 = n_rise; f0 = n_fe; o0 = n_ovr;
    tick(1);
    c0 = cyc;
    send(8'hA5);
    tick(5);
    total++;
    if (n_rise - r0 !== 1) begin
      bad++;
      $display("FAIL basic_pulses: got %0d tvalid pulses, required 1", n_rise - r0);
    end
    total++;
    if (rise_cyc - c0 !== 155) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles, required 155", rise_cyc - c0);
    end
    total++;
    if (n_fe !== f0 || n_ovr !== o0 || q.size() !== 0) begin
      bad++;
      $display("FAIL basic_errors: fe=%0d ovr=%0d pending=%0d, required %0d/%0d/0", n_fe, n_ovr, q.size(), f0, o0);
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] words[3];
    int r0, h0, f0, o0;
    words = '{8'h00, 8'hFF, 8'h5A};
    r0 = n_rise; h0 = n_hs; f0 = n_fe; o0 = n_ovr;
    foreach (words[i]) send(words[i]);
    tick(5);
    total++;
    if (n_rise - r0 !== 3 || n_hs - h0 !== 3) begin
      bad++;
      $display("FAIL b2b_count: pulses=%0d handshakes=%0d, required 3/3", n_rise - r0, n_hs - h0);
    end
    total++;
    if (n_fe !== f0 || n_ovr !== o0 || q.size() !== 0) begin
      bad++;
      $display("FAIL b2b_errors: fe=%0d ovr=%0d pending=%0d, required %0d/%0d/0", n_fe, n_ovr, q.size(), f0, o0);
    end
  endtask
  task automatic test_overrun;
    int o0;
    logic [7:0] dropped;
    o0 = n_ovr;
    tready = 1'b0;
    send(8'h11);
    send(8'h22);
    tick(3);
    total++;
    if (n_ovr - o0 !== 1) begin
      bad++;
      $display("FAIL overrun_pulse: got %0d pulses, required 1", n_ovr - o0);
    end
    total++;
    if (tvalid !== 1'b1 || tdata !== 8'h22) begin
      bad++;
      $display("FAIL overrun_data: tvalid=%b tdata=%h, required 1/22", tvalid, tdata);
    end
    dropped = q.pop_front();
    tready = 1'b1;
    tick(1);
    total++;
    if (tvalid !== 1'b0 || q.size() !== 0) begin
      bad++;
      $display("FAIL overrun_accept: tvalid=%b pending=%0d (dropped %h), required 0/0", tvalid, q.size(), dropped);
    end
  endtask
  task automatic test_frame_error;
    int f0, r0;
    logic seen;
    f0 = n_fe; r0 = n_rise; seen = 1'b0;
    send_bits(8'h3C, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      seen |= busy;
    end
    total++;
    if (n_fe - f0 !== 1 || n_rise !== r0) begin
      bad++;
      $display("FAIL frame_error: fe pulses=%0d tvalid pulses=%0d, required 1/0", n_fe - f0, n_rise - r0);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL frame_low_hold: busy seen=%b, required 0", seen);
    end
    rxd_i = 1'b1;
    tick(20);
    send(8'h3C);
    tick(5);
    total++;
    if (n_rise - r0 !== 1 || q.size() !== 0) begin
      bad++;
      $display("FAIL frame_recover: pulses=%0d pending=%0d, required 1/0", n_rise - r0, q.size());
    end
  endtask
  task automatic test_glitch;
    int r0, f0, o0;
    logic seen;
    r0 = n_rise; f0 = n_fe; o0 = n_ovr; seen = 1'b0;
    prescale_i = 16'd4;
    tick(1);
    rxd_i = 1'b0;
    tick(4);
    rxd_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      seen |= busy;
    end
    total++;
    if (seen !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy: seen=%b final=%b, required 1/0", seen, busy);
    end
    total++;
    if (n_rise !== r0 || n_fe !== f0 || n_ovr !== o0) begin
      bad++;
      $display("FAIL glitch_quiet: pulses=%0d fe=%0d ovr=%0d, required 0/0/0", n_rise - r0, n_fe - f0, n_ovr - o0);
    end
    prescale_i = 16'd2;
  endtask
  task automatic test_reset_mid;
    int r0, f0;
    logic [7:0] d;
    r0 = n_rise; f0 = n_fe;
    d = 8'hC3;
    tick(1);
    rxd_i = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rxd_i = d[i];
      tick(16);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: busy=%b before reset, required 1", busy);
    end
    rst = 1'b1;
    rxd_i = 1'b1;
    tick(1);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b after reset, required 0", busy);
    end
    tick(30);
    total++;
    if (n_rise !== r0 || tvalid !== 1'b0 || n_fe !== f0) begin
      bad++;
      $display("FAIL mid_discard: pulses=%0d tvalid=%b fe=%0d, required 0/0/0", n_rise - r0, tvalid, n_fe - f0);
    end
    send(8'h81);
    tick(5);
    total++;
    if (n_rise - r0 !== 1 || q.size() !== 0) begin
      bad++;
      $display("FAIL mid_recover: pulses=%0d pending=%0d, required 1/0", n_rise - r0, q.size());
    end
  endtask
  initial begin
    test_reset;
    test_prescale_zero;
    test_basic;
    test_back_to_back;
    test_overrun;
    test_frame_error;
    test_glitch;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
